fe25519_inverter: RTL and testbench



---
 rtl/fe25519_inverter.sv | 200 ++++++++++++++++++++
 tb/tb_fe25519_inverter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fe25519_inverter.sv
// Multiplicative inverter over GF(2^255 - 19).
// Binary extended Euclidean algorithm, one step per clock, with a
// start/busy/done handshake. The operand is folded into 0..p-1 first, then
// u/v are driven toward 1 while x1/x2 track u = x1*a and v = x2*a (mod p).
`timescale 1ns/1ps

module fe25519_inverter #(
    parameter int MAX_ITER = 1024,
    parameter int CNT_W    = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] a,
    output logic         busy,
    output logic         done,
    output logic [254:0] result,
    output logic         zero_err
);

    // p = 2^255 - 19: 250 ones followed by 01101
    localparam logic [254:0] P    = {{250{1'b1}}, 5'b01101};
    localparam logic [255:0] P256 = {1'b0, P};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [255:0]   a_reg, a_next;
    logic [254:0]   u_reg, u_next;
    logic [254:0]   v_reg, v_next;
    logic [254:0]   x1_reg, x1_next;
    logic [254:0]   x2_reg, x2_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [254:0]   result_reg, result_next;
    logic           zero_err_reg, zero_err_next;

    // Operand fold: 2^255 = 19 (mod p), so bit 255 contributes 19.
    // The folded value is below 2p, so a single conditional subtract suffices.
    logic [255:0] fold;
    logic [255:0] fold_sub;
    logic         fold_ge;
    logic [254:0] r;

    assign fold     = {1'b0, a_reg[254:0]} + (a_reg[255] ? 256'd19 : 256'd0);
    assign fold_sub = fold - P256;
    assign fold_ge  = (fold >= P256);
    assign r        = fold_ge ? fold_sub[254:0] : fold[254:0];

    // Halving mod p: odd values get +p first so the shift is exact.
    logic [255:0] x1_sum, x2_sum;
    logic [254:0] x1_half, x2_half;

    assign x1_sum  = {1'b0, x1_reg} + (x1_reg[0] ? P256 : 256'd0);
    assign x2_sum  = {1'b0, x2_reg} + (x2_reg[0] ? P256 : 256'd0);
    assign x1_half = x1_sum[255:1];
    assign x2_half = x2_sum[255:1];

    // u/v subtraction; the borrow of u - v doubles as the u >= v compare.
    logic [255:0] uv_diff, vu_diff;
    logic         u_ge_v;

    assign uv_diff = {1'b0, u_reg} - {1'b0, v_reg};
    assign vu_diff = {1'b0, v_reg} - {1'b0, u_reg};
    assign u_ge_v  = ~uv_diff[255];

    // Modular subtraction of the x coefficients: add p back on borrow.
    logic [255:0] x12_diff, x21_diff, x12_fix, x21_fix;
    logic [254:0] x1_sub, x2_sub;

    assign x12_diff = {1'b0, x1_reg} - {1'b0, x2_reg};
    assign x21_diff = {1'b0, x2_reg} - {1'b0, x1_reg};
    assign x12_fix  = x12_diff + P256;
    assign x21_fix  = x21_diff + P256;
    assign x1_sub   = x12_diff[255] ? x12_fix[254:0] : x12_diff[254:0];
    assign x2_sub   = x21_diff[255] ? x21_fix[254:0] : x21_diff[254:0];

    // Carry/LSB bits that are structurally zero or not needed downstream.
    logic unused_bits;
    assign unused_bits = ^{fold_sub[255], x1_sum[0], x2_sum[0], vu_diff[255],
                           x12_fix[255], x21_fix[255]};

    assign busy     = (state_reg == REDUCE) || (state_reg == RUN);
    assign done     = (state_reg == DONE);
    assign result   = result_reg;
    assign zero_err = zero_err_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg        <= '0;
            u_reg        <= '0;
            v_reg        <= '0;
            x1_reg       <= '0;
            x2_reg       <= '0;
            cnt_reg      <= '0;
            result_reg   <= '0;
            zero_err_reg <= 1'b0;
        end else begin
            a_reg        <= a_next;
            u_reg        <= u_next;
            v_reg        <= v_next;
            x1_reg       <= x1_next;
            x2_reg       <= x2_next;
            cnt_reg      <= cnt_next;
            result_reg   <= result_next;
            zero_err_reg <= zero_err_next;
        end
    end

    // Next-state and datapath update: exactly one algorithm step per RUN cycle.
    always_comb begin
        state_next    = state_reg;
        a_next        = a_reg;
        u_next        = u_reg;
        v_next        = v_reg;
        x1_next       = x1_reg;
        x2_next       = x2_reg;
        cnt_next      = cnt_reg;
        result_next   = result_reg;
        zero_err_next = zero_err_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = a;
                    state_next = REDUCE;
                end
            end

            REDUCE: begin
                u_next   = r;
                v_next   = P;
                x1_next  = 255'd1;
                x2_next  = 255'd0;
                cnt_next = '0;
                if (r == 255'd0) begin
                    result_next   = '0;
                    zero_err_next = 1'b1;
                    state_next    = DONE;
                end else begin
                    state_next = RUN;
                end
            end

            RUN: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (u_reg == 255'd1) begin
                    result_next   = x1_reg;
                    zero_err_next = 1'b0;
                    state_next    = DONE;
                end else if (v_reg == 255'd1) begin
                    result_next   = x2_reg;
                    zero_err_next = 1'b0;
                    state_next    = DONE;
                end else if (cnt_reg == CNT_W'(MAX_ITER)) begin
                    // Watchdog: only reachable if the datapath is broken.
                    result_next   = '0;
                    zero_err_next = 1'b1;
                    state_next    = DONE;
                end else if (!u_reg[0]) begin
                    u_next  = u_reg >> 1;
                    x1_next = x1_half;
                end else if (!v_reg[0]) begin
                    v_next  = v_reg >> 1;
                    x2_next = x2_half;
                end else if (u_ge_v) begin
                    u_next  = uv_diff[254:0];
                    x1_next = x1_sub;
                end else begin
                    v_next  = vu_diff[254:0];
                    x2_next = x2_sub;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fe25519_inverter.sv
// Self-checking bench for fe25519_inverter. Expected outcomes are queued when
// an operation is launched and compared when the done pulse appears; every
// nonzero result is verified as result * a == 1 (mod p) with a bench-side
// modular multiplier, plus exact values where they are known in closed form.
`timescale 1ns/1ps

module tb_fe25519_inverter;

    localparam logic [255:0] P256 = {1'b0, {250{1'b1}}, 5'b01101};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [255:0] a = '0;
    logic         busy;
    logic         done;
    logic [254:0] result;
    logic         zero_err;

    fe25519_inverter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero_err (zero_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [254:0] a_red;
        logic [254:0] exp_res;
        bit           has_exp;
        bit           exp_zero;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  n_vec = 0;
    int  n_err = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference reduction by repeated subtraction (independent of the fold trick).
    function automatic logic [254:0] reduce_p(input logic [255:0] x);
        logic [256:0] t;
        t = {1'b0, x};
        while (t >= {1'b0, P256}) t = t - {1'b0, P256};
        return t[254:0];
    endfunction

    // Double-and-add modular multiply, x and y expected below p.
    function automatic logic [254:0] mod_mul(input logic [254:0] x, input logic [254:0] y);
        logic [255:0] acc;
        acc = '0;
        for (int i = 254; i >= 0; i--) begin
            acc = acc << 1;
            if (acc >= P256) acc = acc - P256;
            if (y[i]) begin
                acc = acc + {1'b0, x};
                if (acc >= P256) acc = acc - P256;
            end
        end
        return acc[254:0];
    endfunction

    // Scoreboard consumer: one line per completed transaction.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_done", 256'd1, 256'd0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.exp_zero) begin
                    check_val("zero_err_set", {255'd0, zero_err}, 256'd1);
                    check_val("zero_result", {1'b0, result}, 256'd0);
                end else begin
                    check_val("zero_err_clr", {255'd0, zero_err}, 256'd0);
                    check_val("res_below_p", {255'd0, ({1'b0, result} < P256)}, 256'd1);
                    check_val("res_times_a", {1'b0, mod_mul(result, mon_e.a_red)}, 256'd1);
                    if (mon_e.has_exp)
                        check_val("res_exact", {1'b0, result}, {1'b0, mon_e.exp_res});
                end
                $display("txn a_mod_p=%h result=%h zero_err=%0d", mon_e.a_red, result, zero_err);
            end
        end
    end

    function automatic sb_t make_entry(input logic [255:0] op, input bit has_exp,
                                       input logic [254:0] exp_res);
        sb_t e;
        e.a_red    = reduce_p(op);
        e.exp_zero = (e.a_red == '0);
        e.has_exp  = has_exp;
        e.exp_res  = exp_res;
        return e;
    endfunction

    // Bounded wait for done; on expiry, report, reset the DUT and flush.
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        while (!done && lat < 1100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok = done;
        if (!ok) begin
            check_val("done_timeout", 256'd0, 256'd1);
            rst_n = 1'b0;
            #1;
            sb_q.delete();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
    endtask

    // Launch one operation and wait for it; exp_lat < 0 means only bound-check latency.
    task automatic run_op(input logic [255:0] op, input bit has_exp,
                          input logic [254:0] exp_res, input int exp_lat);
        int lat;
        bit ok;
        @(negedge clk);
        a     = op;
        start = 1'b1;
        sb_q.push_back(make_entry(op, has_exp, exp_res));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
        check_val("busy_after_start", {255'd0, busy}, 256'd1);
        wait_done(lat, ok);
        if (ok) begin
            check_val("busy_at_done", {255'd0, busy}, 256'd0);
            if (exp_lat >= 0)
                check_val("latency", lat, exp_lat);
            else
                check_val("latency_bound", {255'd0, (lat <= 1022)}, 256'd1);
            @(posedge clk);
            #1;
            check_val("done_one_cycle", {255'd0, done}, 256'd0);
        end
    endtask

    initial begin
        logic [254:0] half_inv;
        logic [254:0] pm1;
        logic [255:0] op;
        int           lat;
        bit           ok;

        // Reset, then idle with start low.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("rst_busy", {255'd0, busy}, 256'd0);
            check_val("rst_done", {255'd0, done}, 256'd0);
            check_val("rst_result", {1'b0, result}, 256'd0);
            check_val("rst_zero_err", {255'd0, zero_err}, 256'd0);
        end

        // Closed-form vectors.
        half_inv = 255'd1 << 254;
        half_inv = half_inv - 255'd9;
        pm1      = P256[254:0] - 255'd1;
        run_op(256'd1, 1'b1, 255'd1, 2);
        run_op(256'd2, 1'b1, half_inv, -1);
        run_op({1'b0, pm1}, 1'b1, pm1, -1);
        run_op(256'd0, 1'b0, '0, -1);
        run_op(P256, 1'b0, '0, -1);
        op = P256 + (256'd1 << 255);
        run_op(op, 1'b0, '0, -1);
        run_op(P256 + 256'd1, 1'b1, 255'd1, -1);
        run_op(256'd1 << 255, 1'b0, '0, -1);
        run_op({256{1'b1}}, 1'b0, '0, -1);
        run_op({1'b0, {255{1'b1}}}, 1'b0, '0, -1);

        // Start while busy is ignored; start during the done cycle is ignored.
        @(negedge clk);
        a     = 256'd3;
        start = 1'b1;
        sb_q.push_back(make_entry(256'd3, 1'b0, '0));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("busy_before_restart", {255'd0, busy}, 256'd1);
        start = 1'b1;
        a     = 256'd5;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, ok);
        if (ok) begin
            start = 1'b1;
            a     = 256'd9;
            @(posedge clk);
            #1 start = 1'b0;
            check_val("start_in_done_ignored", {255'd0, busy}, 256'd0);
            @(posedge clk);
            #1;
            check_val("no_extra_op", {255'd0, busy}, 256'd0);
        end

        // Reset mid-RUN: no done for the aborted operation.
        @(negedge clk);
        a     = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom() | 32'd1};
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_val("busy_mid_run", {255'd0, busy}, 256'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_busy", {255'd0, busy}, 256'd0);
        check_val("arst_done", {255'd0, done}, 256'd0);
        check_val("arst_result", {1'b0, result}, 256'd0);
        check_val("arst_zero_err", {255'd0, zero_err}, 256'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("post_rst_quiet", {254'd0, busy, done}, 256'd0);
        end
        run_op(256'd7, 1'b0, '0, -1);

        // Random operands.
        for (int i = 0; i < 40; i++) begin
            op = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            run_op(op, 1'b0, '0, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        check_val("scoreboard_drained", sb_q.size(), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
